// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: holds the PC, reads a word-addressed IMEM and presents instruction/PC+4 to decode.
// Latency: combinational fetch from the current PC; PC, state and halted update on the CLK rising edge.
// Backpressure: stall holds the PC in RUN; redirect overrides stall and flushes the output to NOP the same cycle.
// Optional build macro IF_PERF_CNT_EN adds saturating fetch_count/stall_count outputs.
module if_fetch_stage #(
  parameter int          IMEM_DEPTH   = 512,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic [31:0]                   instruction_out,
  output logic [31:0]                   PCPlus4_out,
  output logic [31:0]                   pc_out,
  output logic                          halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                   fetch_count,
  output logic [31:0]                   stall_count
`endif
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [31:0] TERM_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  logic [31:0] imem [IMEM_DEPTH];

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_cnt_q, drain_cnt_d;
  logic        halted_q, halted_d;

  logic [31:0] fetch_word;
  logic        fetch_term;
  logic [31:0] redirect_tgt;

  // Loader port; memory is intentionally not cleared by reset so a program survives a restart.
  always_ff @(posedge CLK) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // Combinational fetch; any address beyond the array reads as the terminator.
  always_comb begin
    fetch_word = imem[pc_q[AW+1:2]];
    if ((pc_q >> (AW + 2)) != 32'd0) begin
      fetch_word = TERM_WORD;
    end
  end

  assign fetch_term   = (fetch_word == TERM_WORD);
  assign redirect_tgt = redirect_pc & ~32'h3;

  // Decode-facing outputs: wrong-path flush forces NOP, drain/halt keeps presenting the terminator.
  always_comb begin
    instruction_out = fetch_word;
    if (state_q != ST_RUN) begin
      instruction_out = TERM_WORD;
    end
    if (redirect_valid) begin
      instruction_out = 32'h0000_0000;
    end
  end

  assign PCPlus4_out = pc_q + 32'd4;
  assign pc_out      = pc_q;
  assign halted      = halted_q;

  // Next-state: redirect beats stall beats the per-state rule; HALTED only leaves via reset.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (fetch_term) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 32'd1;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          // The terminator was on the wrong path: resume at the target.
          pc_d        = redirect_tgt;
          state_d     = ST_RUN;
          drain_cnt_d = 32'd0;
        end else if (drain_cnt_q == 32'(DRAIN_CYCLES)) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 32'd1;
        end
      end
      ST_HALTED: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      drain_cnt_q <= 32'd0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Saturating event counters, only active while running and not redirected.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (state_q == ST_RUN && !redirect_valid) begin
      if (stall) begin
        if (stall_count_q != 32'hFFFF_FFFF) stall_count_d = stall_count_q + 32'd1;
      end else if (!fetch_term) begin
        if (fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, stall, redirect/flush, drain/halt, wrong-path terminator,
// out-of-range fetch, PC+4 wrap, reset from HALTED and same-address load.
// Inputs change and outputs are checked on the falling edge; the DUT updates on the rising edge.
module tb_if_fetch_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        imem_we;
  logic [8:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction_out;
  logic [31:0] PCPlus4_out;
  logic [31:0] pc_out;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  if_fetch_stage #(.IMEM_DEPTH(512), .RESET_PC(32'h0), .DRAIN_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction_out(instruction_out), .PCPlus4_out(PCPlus4_out), .pc_out(pc_out),
    .halted(halted)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle on the falling edge where checks happen.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic load(input logic [8:0] a, input logic [31:0] d);
    @(negedge CLK);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    @(posedge CLK);
    #1 imem_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    #1;
  endtask

  initial begin
    RESET = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    load(9'd0,  32'h2008_0001);
    load(9'd1,  32'h2009_0002);
    load(9'd2,  32'h0109_5020);
    load(9'd3,  32'hFFFF_FFFF);
    load(9'd8,  32'h1111_1111);
    load(9'd16, 32'hAAAA_0000);

    // Reset state
    step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    RESET = 1'b0;
    #1;

    // Sequential fetch
    chk("seq_pc0", pc_out, 32'h0);
    chk("seq_ins0", instruction_out, 32'h2008_0001);
    chk("seq_p4_0", PCPlus4_out, 32'h4);
    step();
    chk("seq_pc4", pc_out, 32'h4);
    chk("seq_ins4", instruction_out, 32'h2009_0002);
    chk("seq_p4_4", PCPlus4_out, 32'h8);

    // Stall two edges at PC=4
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_pc", pc_out, 32'h4);
      chk("stall_ins", instruction_out, 32'h2009_0002);
      chk("stall_p4", PCPlus4_out, 32'h8);
    end
    stall = 1'b0;
    step();
    chk("post_stall_pc", pc_out, 32'h8);
    chk("seq_ins8", instruction_out, 32'h0109_5020);
    chk("seq_p4_8", PCPlus4_out, 32'hC);
`ifdef IF_PERF_CNT_EN
    chk("perf_stall", stall_count, 32'd2);
    chk("perf_fetch", fetch_count, 32'd2);
`endif

    // Redirect with stall: redirect wins, output flushed to NOP
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("flush_nop", instruction_out, 32'h0);
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("redir_pc", pc_out, 32'h40);
    chk("redir_ins", instruction_out, 32'hAAAA_0000);

    // Unaligned target: low bits dropped
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("redir_align", pc_out, 32'h40);

    // Back to PC=8, run to the terminator at 12
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    step();
    chk("term_pc", pc_out, 32'hC);
    chk("term_ins", instruction_out, 32'hFFFF_FFFF);
    chk("term_p4", PCPlus4_out, 32'h10);

    // Drain: halted rises on the 4th edge after the fetch edge
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("drain_pc_%0d", k), pc_out, 32'hC);
      chk($sformatf("drain_ins_%0d", k), instruction_out, 32'hFFFF_FFFF);
      chk($sformatf("drain_halt_%0d", k), {31'd0, halted}, (k == 5) ? 32'd1 : 32'd0);
    end

    // Redirect and stall ignored once halted
    redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    step();
    chk("halt_pc_frozen", pc_out, 32'hC);
    chk("halt_sticky", {31'd0, halted}, 32'd1);

    // Reset from HALTED: PC back to RESET_PC, memory preserved
    do_reset();
    chk("rst2_pc", pc_out, 32'h0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_mem", instruction_out, 32'h2008_0001);

    // Wrong-path terminator: redirect during the 2nd DRAIN cycle
    step(); step(); step();
    chk("wp_pc12", pc_out, 32'hC);
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("wp_pc", pc_out, 32'h20);
    chk("wp_ins", instruction_out, 32'h1111_1111);
    chk("wp_halted", {31'd0, halted}, 32'd0);
    step();
    chk("wp_run_pc", pc_out, 32'h24);
    chk("wp_run_halted", {31'd0, halted}, 32'd0);

    // Out-of-range PC reads as terminator and drains
    redirect_valid = 1'b1; redirect_pc = 32'h800;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("oor_pc", pc_out, 32'h800);
    chk("oor_ins", instruction_out, 32'hFFFF_FFFF);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("oor_pc_%0d", k), pc_out, 32'h800);
      chk($sformatf("oor_halt_%0d", k), {31'd0, halted}, (k == 5) ? 32'd1 : 32'd0);
    end

    // PC+4 wraps modulo 2^32
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_p4", PCPlus4_out, 32'h0);
    chk("wrap_ins", instruction_out, 32'hFFFF_FFFF);

    // Load into the addressed word: old value now, new value next cycle
    do_reset();
    stall = 1'b1;
    imem_we = 1'b1; imem_waddr = 9'd0; imem_wdata = 32'h1234_5678;
    #1;
    chk("wr_old", instruction_out, 32'h2008_0001);
    step();
    imem_we = 1'b0;
    #1;
    chk("wr_new", instruction_out, 32'h1234_5678);
    chk("wr_pc", pc_out, 32'h0);
    stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline and the producer side of the IF→ID interface. It holds the PC and reads a word-addressed instruction memory. It presents instruction_out and PCPlus4_out for the decode stage to latch on the next CLK rising edge. It handles stalls, branch/jump redirects and wrong-path flush, and drives the halt sequence when the terminator word 32'hFFFFFFFF is fetched.

Parameters:
IMEM_DEPTH, 512, instruction memory size in 32-bit words; must be a power of 2.
RESET_PC, 32'h00000000, PC value loaded on reset.
DRAIN_CYCLES, 4, cycles to hold after fetching the terminator before asserting halted.

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
imem_we  input  1  instruction-memory load strobe (bench/loader)
imem_waddr  input  log2(IMEM_DEPTH)  word address for load
imem_wdata  input  32  word to load
stall  input  1  hold PC; outputs unchanged (hazard unit)
redirect_valid  input  1  branch taken or jump resolved this cycle
redirect_pc  input  32  target PC for redirect
instruction_out  output  32  fetched instruction to decode stage
PCPlus4_out  output  32  PC+4 of the fetched instruction
pc_out  output  32  current PC (debug)
halted  output  1  terminator drained; pipeline finished

Behaviour:
- Memory: IMEM_DEPTH x 32 array, written on CLK when imem_we=1. Not cleared by RESET.
- Memory read: combinational, index = PC[log2(IMEM_DEPTH)+1:2].
- Out of range: if PC[31:log2(IMEM_DEPTH)+2] != 0, the fetched word is 32'hFFFFFFFF (treated as terminator).
- Outputs:
  - instruction_out = fetched word, except forced to 32'h00000000 (NOP) whenever redirect_valid=1 (wrong-path flush, same cycle).
  - PCPlus4_out = PC+4, computed modulo 2^32 (wraps).
  - pc_out = PC.
- Reset: PC←RESET_PC, state←RUN, drain counter←0, halted←0. RESET overrides every other input. Reset in DRAIN or HALTED returns to RUN.
- State machine RUN/DRAIN/HALTED; next-PC priority per edge: RESET > redirect_valid > stall > state rule.
  - RUN:
    - redirect_valid=1: PC←{redirect_pc[31:2],2'b00}; any low bits are silently dropped.
    - stall=1: PC holds.
    - fetched word == FFFFFFFF: PC holds, state←DRAIN, counter←1.
    - otherwise: PC←PC+4.
  - DRAIN:
    - PC holds; instruction_out keeps presenting FFFFFFFF.
    - counter increments each edge and is not gated by stall.
    - when counter==DRAIN_CYCLES, state←HALTED.
    - redirect_valid=1 in DRAIN: the terminator was wrong-path; PC←redirect_pc, state←RUN, counter←0.
  - HALTED:
    - halted=1 (registered; rises on the edge entering HALTED).
    - PC frozen; stall and redirect ignored; only RESET exits.
- Latency: an instruction fetched in cycle N is latched by decode at the end of cycle N. Redirect takes effect at the edge closing the redirect cycle, and the target is fetched in cycle N+1.
- Simultaneous events:
  - stall=1 with redirect_valid=1: redirect wins and instruction_out is NOP.
  - imem_we writing the currently addressed word: the read returns the old value this cycle and the new value next cycle.
  - Load while running is legal; no hazard protection.

Optional Feature:
IF_PERF_CNT_EN:
- When defined, adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
- fetch_count increments on each edge where state=RUN, stall=0, redirect_valid=0 and the word is not the terminator.
- stall_count increments on each edge where state=RUN and stall=1 and redirect_valid=0.
- Both counters saturate at 32'hFFFFFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Sequential fetch: load words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0xFFFFFFFF; release RESET → PC 0,4,8,12. PCPlus4_out 4,8,12,16. instruction_out matches memory each cycle.
- Stall: stall=1 for 2 cycles at PC=4 → PC, instruction_out 0x20090002 and PCPlus4_out 8 held 2 cycles, then PC=8. With IF_PERF_CNT_EN, stall_count=2.
- Redirect + flush:
  - redirect_valid=1, redirect_pc=0x40 at PC=8 with stall=1 → instruction_out=0 that cycle; next cycle PC=0x40.
  - redirect_pc=0x43 → PC=0x40.
- Halt drain: fetch FFFFFFFF at PC=12 → PC stays 12 and instruction_out=FFFFFFFF. halted rises exactly DRAIN_CYCLES=4 edges after the fetch edge. Later redirect is ignored.
- Wrong-path terminator: redirect_valid=1 (pc 0x20) in the 2nd DRAIN cycle → state RUN, PC=0x20, halted stays 0.
- Boundary/reset:
  - PC=4*IMEM_DEPTH (0x800) → fetched FFFFFFFF, enters DRAIN.
  - RESET=1 in HALTED → next cycle PC=RESET_PC, halted=0, memory contents preserved.
